// File: rtl/vip_maxpool2d_0.sv
// vip_maxpool2d_0: 2x2 stride-2 signed max-pool of a raster pixel stream into a show-ahead output FIFO
module vip_maxpool2d_0 #(
  parameter int DWIDTH = 32,
  parameter int IMG_W = 30,
  parameter int IMG_H = 30,
  parameter int OUT_DEPTH = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DWIDTH-1:0] fifo_in_data,
  input  logic              fifo_in_wrreq,
  output logic              fifo_in_full,
  output logic [DWIDTH-1:0] fifo_out_data,
  input  logic              fifo_out_rdreq,
  output logic              fifo_out_empty,
  output logic              frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int LN = IMG_W / 2;
  localparam int LW = LN > 1 ? $clog2(LN) : 1;
  localparam int PW = $clog2(OUT_DEPTH);
  localparam int NW = PW + 1;
  function automatic logic [DWIDTH-1:0] smax(input logic signed [DWIDTH-1:0] a, input logic signed [DWIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [DWIDTH-1:0] hold_q, hold_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic done_q, done_d;
  logic [DWIDTH-1:0] linebuf [LN];
  logic [DWIDTH-1:0] mem [OUT_DEPTH];
  logic acc, last_col, last_row, push, pop;
  logic [LW-1:0] lb_idx;
  logic [DWIDTH-1:0] pair, result;
  assign acc = fifo_in_wrreq & ~fifo_in_full;
  assign last_col = col_q == CW'(IMG_W - 1);
  assign last_row = row_q == RW'(IMG_H - 1);
  assign lb_idx = LW'(col_q >> 1);
  assign pair = smax(hold_q, fifo_in_data);
  assign result = smax(linebuf[lb_idx], pair);
  assign push = acc & col_q[0] & row_q[0];
  assign pop = fifo_out_rdreq & ~fifo_out_empty;
  assign fifo_in_full = cnt_q == NW'(OUT_DEPTH);
  assign fifo_out_empty = cnt_q == '0;
  assign fifo_out_data = fifo_out_empty ? '0 : mem[rd_q];
  assign frame_done = done_q;
  always_comb begin
    col_d = acc ? (last_col ? '0 : col_q + CW'(1)) : col_q;
    row_d = (acc && last_col) ? (last_row ? '0 : row_q + RW'(1)) : row_q;
    hold_d = (acc && !col_q[0]) ? fifo_in_data : hold_q;
    cnt_d = cnt_q + NW'(push) - NW'(pop);
    wr_d = wr_q + PW'(push);
    rd_d = rd_q + PW'(pop);
    done_d = push & last_row & last_col;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_q <= '0;
      row_q <= '0;
      hold_q <= '0;
      cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      done_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      hold_q <= hold_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      done_q <= done_d;
    end
  end
  always_ff @(posedge clock) begin
    if (acc && col_q[0] && !row_q[0]) linebuf[lb_idx] <= pair;
    if (push) mem[wr_q] <= result;
  end
endmodule

// File: tb/tb_vip_maxpool2d_0.sv
// tb_vip_maxpool2d_0: scoreboard bench for the 2x2 max-pool stage on a 4x4 and a 30x30 instance
module tb_vip_maxpool2d_0;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  logic [31:0] a_din, a_dout, b_din, b_dout;
  logic a_wr, a_rd, a_full, a_empty, a_done;
  logic b_wr, b_rd, b_full, b_empty, b_done;
  int n_chk = 0;
  int n_fail = 0;
  logic signed [31:0] sb[$];
  int due[$];
  vip_maxpool2d_0 #(.DWIDTH(32), .IMG_W(4), .IMG_H(4), .OUT_DEPTH(2)) u_a (
    .clock(clk), .reset(rst_n), .fifo_in_data(a_din), .fifo_in_wrreq(a_wr), .fifo_in_full(a_full),
    .fifo_out_data(a_dout), .fifo_out_rdreq(a_rd), .fifo_out_empty(a_empty), .frame_done(a_done));
  vip_maxpool2d_0 u_b (
    .clock(clk), .reset(rst_n), .fifo_in_data(b_din), .fifo_in_wrreq(b_wr), .fifo_in_full(b_full),
    .fifo_out_data(b_dout), .fifo_out_rdreq(b_rd), .fifo_out_empty(b_empty), .frame_done(b_done));
  function automatic logic signed [31:0] mx(input logic signed [31:0] x, input logic signed [31:0] y);
    return x > y ? x : y;
  endfunction
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    a_wr = 1'b0; a_rd = 1'b0; b_wr = 1'b0; b_rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    due.delete();
  endtask
  task automatic stream4(input logic signed [31:0] px[16], output int ndone);
    int i, cyc, t;
    logic signed [31:0] e;
    i = 0; cyc = 0; ndone = 0;
    sb.delete(); due.delete();
    a_rd = 1'b1;
    while ((i < 16 || sb.size() != 0) && cyc < 100) begin
      @(negedge clk);
      if (a_done) ndone++;
      if (!a_empty) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL stream4_extra: got %0d, required no output", $signed(a_dout));
        end else begin
          e = sb.pop_front();
          t = due.pop_front();
          if (a_dout !== e || cyc != t) begin
            n_fail++;
            $display("FAIL stream4_out: got %0d at cycle %0d, required %0d at cycle %0d", $signed(a_dout), cyc, e, t);
          end
        end
      end
      if (i < 16 && !a_full) begin
        a_wr = 1'b1;
        a_din = px[i];
        if ((i / 4) % 2 == 1 && i % 2 == 1) begin
          sb.push_back(mx(mx(px[i], px[i-1]), mx(px[i-4], px[i-5])));
          due.push_back(cyc + 1);
        end
        i++;
      end else a_wr = 1'b0;
      cyc++;
    end
    a_wr = 1'b0;
    n_chk++;
    if (i != 16 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL stream4_timeout: sent %0d pending %0d, required 16 sent 0 pending", i, sb.size());
    end
    @(negedge clk);
    if (a_done) ndone++;
    n_chk++;
    if (a_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL stream4_drained: empty=%b, required 1", a_empty);
    end
    a_rd = 1'b0;
  endtask
  task automatic test_reset();
    #2;
    n_chk += 8;
    if (a_full !== 1'b0) begin n_fail++; $display("FAIL reset_a_full: got %b, required 0", a_full); end
    if (a_empty !== 1'b1) begin n_fail++; $display("FAIL reset_a_empty: got %b, required 1", a_empty); end
    if (a_dout !== 32'd0) begin n_fail++; $display("FAIL reset_a_data: got %h, required 0", a_dout); end
    if (a_done !== 1'b0) begin n_fail++; $display("FAIL reset_a_done: got %b, required 0", a_done); end
    if (b_full !== 1'b0) begin n_fail++; $display("FAIL reset_b_full: got %b, required 0", b_full); end
    if (b_empty !== 1'b1) begin n_fail++; $display("FAIL reset_b_empty: got %b, required 1", b_empty); end
    if (b_dout !== 32'd0) begin n_fail++; $display("FAIL reset_b_data: got %h, required 0", b_dout); end
    if (b_done !== 1'b0) begin n_fail++; $display("FAIL reset_b_done: got %b, required 0", b_done); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_ramp();
    logic signed [31:0] px[16];
    int nd;
    for (int k = 0; k < 16; k++) px[k] = k;
    stream4(px, nd);
    n_chk++;
    if (nd != 1) begin n_fail++; $display("FAIL ramp_frame_done: got %0d pulses, required 1", nd); end
  endtask
  task automatic test_signed();
    logic signed [31:0] px[16];
    int nd;
    for (int k = 0; k < 16; k++) px[k] = -(k + 1);
    stream4(px, nd);
    for (int k = 0; k < 16; k++) px[k] = -100;
    px[0] = -5; px[1] = 3; px[4] = 0; px[5] = -7;
    stream4(px, nd);
    n_chk++;
    if (nd != 1) begin n_fail++; $display("FAIL signed_frame_done: got %0d pulses, required 1", nd); end
  endtask
  task automatic test_push_pop();
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      a_wr = 1'b1; a_din = k;
    end
    @(negedge clk);
    a_din = 6;
    n_chk++;
    if (a_empty !== 1'b0 || a_dout !== 32'd5) begin n_fail++; $display("FAIL pp_first: empty=%b data=%0d, required 0/5", a_empty, a_dout); end
    @(negedge clk);
    a_din = 7; a_rd = 1'b1;
    n_chk++;
    if (a_dout !== 32'd5) begin n_fail++; $display("FAIL pp_hold: got %0d, required 5", a_dout); end
    @(negedge clk);
    a_wr = 1'b0; a_rd = 1'b0;
    n_chk++;
    if (a_empty !== 1'b0 || a_full !== 1'b0 || a_dout !== 32'd7) begin
      n_fail++; $display("FAIL pp_swap: empty=%b full=%b data=%0d, required 0/0/7", a_empty, a_full, a_dout);
    end
    @(negedge clk);
    a_rd = 1'b1;
    @(negedge clk);
    a_rd = 1'b0;
    n_chk++;
    if (a_empty !== 1'b1) begin n_fail++; $display("FAIL pp_count: empty=%b, required 1", a_empty); end
  endtask
  task automatic test_backpressure();
    int acc_n;
    apply_reset();
    acc_n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_chk++;
      if (a_full !== (c >= 8)) begin n_fail++; $display("FAIL bp_full_c%0d: got %b, required %b", c, a_full, c >= 8); end
      a_wr = 1'b1; a_din = acc_n % 16;
      if (!a_full) acc_n++;
    end
    n_chk++;
    if (acc_n != 8 || a_dout !== 32'd5) begin n_fail++; $display("FAIL bp_freeze: accepted=%0d head=%0d, required 8/5", acc_n, a_dout); end
    @(negedge clk);
    a_rd = 1'b1;
    if (!a_full) acc_n++;
    @(negedge clk);
    a_rd = 1'b0;
    n_chk++;
    if (a_full !== 1'b0 || a_dout !== 32'd7) begin n_fail++; $display("FAIL bp_release: full=%b head=%0d, required 0/7", a_full, a_dout); end
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      a_wr = 1'b1; a_din = acc_n % 16;
      if (!a_full) acc_n++;
    end
    @(negedge clk);
    a_wr = 1'b0; a_rd = 1'b1;
    n_chk++;
    if (acc_n != 14 || a_full !== 1'b1 || a_dout !== 32'd7) begin
      n_fail++; $display("FAIL bp_one_more: accepted=%0d full=%b head=%0d, required 14/1/7", acc_n, a_full, a_dout);
    end
    @(negedge clk);
    n_chk++;
    if (a_empty !== 1'b0 || a_dout !== 32'd13) begin n_fail++; $display("FAIL bp_drain: empty=%b head=%0d, required 0/13", a_empty, a_dout); end
    @(negedge clk);
    a_rd = 1'b0;
    n_chk++;
    if (a_empty !== 1'b1) begin n_fail++; $display("FAIL bp_empty: got %b, required 1", a_empty); end
  endtask
  task automatic test_reset_midframe();
    logic signed [31:0] px[16];
    int nd;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      a_wr = 1'b1; a_din = k;
    end
    @(negedge clk);
    a_wr = 1'b0;
    n_chk++;
    if (a_empty !== 1'b0) begin n_fail++; $display("FAIL mid_pre: empty=%b, required 0", a_empty); end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_chk++;
    if (a_empty !== 1'b1 || a_full !== 1'b0 || a_dout !== 32'd0 || a_done !== 1'b0) begin
      n_fail++; $display("FAIL mid_async: empty=%b full=%b data=%0d done=%b, required 1/0/0/0", a_empty, a_full, a_dout, a_done);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 16; k++) px[k] = k;
    stream4(px, nd);
    n_chk++;
    if (nd != 1) begin n_fail++; $display("FAIL mid_frame_done: got %0d pulses, required 1", nd); end
  endtask
  task automatic test_back_to_back();
    logic signed [31:0] fr[900];
    logic signed [31:0] p, e;
    int i, cyc, j, nd, nout;
    i = 0; cyc = 0; nd = 0; nout = 0;
    sb.delete();
    while ((i < 1800 || sb.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      if (b_done) nd++;
      b_rd = $urandom_range(3) != 0;
      if (!b_empty && b_rd) begin
        n_chk++;
        nout++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra: got %0d, required no output", $signed(b_dout));
        end else begin
          e = sb.pop_front();
          if (b_dout !== e) begin n_fail++; $display("FAIL b2b_out%0d: got %0d, required %0d", nout, $signed(b_dout), e); end
        end
      end
      if (i < 1800 && !b_full) begin
        p = $urandom;
        j = i % 900;
        fr[j] = p;
        b_wr = 1'b1; b_din = p;
        if ((j / 30) % 2 == 1 && j % 2 == 1) sb.push_back(mx(mx(p, fr[j-1]), mx(fr[j-30], fr[j-31])));
        i++;
      end else b_wr = 1'b0;
      cyc++;
    end
    b_wr = 1'b0; b_rd = 1'b0;
    @(negedge clk);
    if (b_done) nd++;
    n_chk += 2;
    if (nout != 450 || sb.size() != 0) begin n_fail++; $display("FAIL b2b_count: got %0d words pending %0d, required 450/0", nout, sb.size()); end
    if (nd != 2) begin n_fail++; $display("FAIL b2b_frame_done: got %0d pulses, required 2", nd); end
  endtask
  initial begin
    rst_n = 1'b0;
    a_wr = 1'b0; a_rd = 1'b0; a_din = '0;
    b_wr = 1'b0; b_rd = 1'b0; b_din = '0;
    test_reset();
    test_ramp();
    test_signed();
    test_push_pop();
    test_backpressure();
    test_reset_midframe();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
